// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: fetch stage issuing one valid/ready read per pc,
// turning misaligned pcs, bus errors and missing responses into error pulses.
module rv32i_fetch_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic                  fetch_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  fetch_err,
  output logic [1:0]            err_cause,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_BUS      = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign fetch_ready   = (state == IDLE);
  assign mem_req_valid = (state == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      err_cause   <= 2'b00;
      mem_addr    <= '0;
    end else begin
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_req && !flush) begin
            if (pc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              err_cause <= CAUSE_MISALIGN;
            end else begin
              mem_addr <= pc;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= flush ? DRAIN : WAIT;
          end else if (flush) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
          // a response beats a same-cycle timeout; flush suppresses both
          if (mem_rsp_valid) begin
            state <= IDLE;
            if (!flush) begin
              if (mem_rsp_err) begin
                fetch_err <= 1'b1;
                err_cause <= CAUSE_BUS;
              end else begin
                instr       <= mem_rsp_data;
                instr_valid <= 1'b1;
              end
            end
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            if (!flush) begin
              fetch_err <= 1'b1;
              err_cause <= CAUSE_TIMEOUT;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_rsp_valid || cnt == CNT_MAX)
            state <= IDLE;
          else
            cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// tb_rv32i_fetch_unit: directed and randomized fetch transactions
// checked against a transaction-level timing model.
module tb_rv32i_fetch_unit;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        fetch_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [1:0]  err_cause;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_instr = '0;
  logic [1:0]  exp_cause = 2'b00;

  rv32i_fetch_unit #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_req(fetch_req),
    .pc(pc),
    .flush(flush),
    .fetch_ready(fetch_ready),
    .instr(instr),
    .instr_valid(instr_valid),
    .fetch_err(fetch_err),
    .err_cause(err_cause),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Open-loop transaction: fetch_req at cycle 0, ready only at cycle
  // 1+rdly, one response at (1+rdly)+sdly, flush at cycle fl_cyc.
  task automatic drive_txn(
    input  logic [31:0] a,
    input  int          rdly,
    input  int          sdly,
    input  logic        rerr,
    input  logic [31:0] data,
    input  int          fl_cyc,
    input  int          ncyc,
    output int          ev_cyc,
    output int          ev_kind,
    output logic [31:0] ev_instr,
    output logic [1:0]  ev_cause,
    output int          npulse,
    output int          req_seen,
    output int          req_bad,
    output int          both,
    output int          ready_at
  );
    int h;
    h = 1 + rdly;
    ev_cyc = -1;
    ev_kind = 0;
    ev_instr = '0;
    ev_cause = 2'b00;
    npulse = 0;
    req_seen = 0;
    req_bad = 0;
    both = 0;
    ready_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (c >= 1) begin
        if (instr_valid || fetch_err) begin
          npulse++;
          if (ev_kind == 0) begin
            ev_cyc = c;
            ev_kind = instr_valid ? 1 : 2;
            ev_instr = instr;
            ev_cause = err_cause;
          end
        end
        if (instr_valid && fetch_err) both++;
        if (mem_req_valid) begin
          req_seen++;
          if (mem_addr !== a) req_bad++;
        end
        if (fetch_ready && ready_at < 0) ready_at = c;
      end
      fetch_req = (c == 0);
      pc = (c == 0) ? a : 32'hDEAD_BEE0;
      flush = (c == fl_cyc);
      mem_req_ready = (c == h);
      mem_rsp_valid = (c == h + sdly);
      mem_rsp_err = rerr;
      mem_rsp_data = data;
      tick();
    end
    fetch_req = 1'b0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err = 1'b0;
  endtask

  // Expected outcome from the timing rules: kind 1=valid, 2=error.
  function automatic void model_txn(
    input  logic [31:0] a,
    input  int          rdly,
    input  int          sdly,
    input  logic        rerr,
    output int          cyc,
    output int          kind,
    output logic [1:0]  cause,
    output int          nreq
  );
    int h;
    h = 1 + rdly;
    if (a[1:0] != 2'b00) begin
      cyc = 1; kind = 2; cause = 2'b01; nreq = 0;
    end else if (sdly >= 1 && sdly <= T) begin
      cyc = h + sdly + 1;
      kind = rerr ? 2 : 1;
      cause = 2'b11;
      nreq = rdly + 1;
    end else begin
      cyc = h + T + 1; kind = 2; cause = 2'b10; nreq = rdly + 1;
    end
  endfunction

  int ec, ek, np, rs, rb, bo, ra;
  logic [31:0] ei;
  logic [1:0]  eca;

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", fetch_ready); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if (err_cause !== 2'b00) begin bad++; $display("FAIL reset_cause got=%b exp=00", err_cause); end
    total++; if ({instr_valid, fetch_err, mem_req_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses got=%b exp=000", {instr_valid, fetch_err, mem_req_valid});
    end
    exp_instr = '0;
    exp_cause = 2'b00;
  endtask

  task automatic test_basic();
    drive_txn(32'h40, 0, 1, 1'b0, 32'h0050_0093, -1, 6, ec, ek, ei, eca, np, rs, rb, bo, ra);
    exp_instr = 32'h0050_0093;
    total++; if (ec !== 3 || ek !== 1) begin bad++; $display("FAIL basic_latency got cyc=%0d kind=%0d exp cyc=3 kind=1", ec, ek); end
    total++; if (ei !== exp_instr) begin bad++; $display("FAIL basic_instr got=%h exp=%h", ei, exp_instr); end
    total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL basic_addr got=%h exp=40", mem_addr); end
    total++; if (rs !== 1 || rb !== 0) begin bad++; $display("FAIL basic_req got seen=%0d bad=%0d exp 1/0", rs, rb); end
  endtask

  task automatic test_misaligned();
    drive_txn(32'h42, 0, 1, 1'b0, 32'h1111_1111, -1, 5, ec, ek, ei, eca, np, rs, rb, bo, ra);
    exp_cause = 2'b01;
    total++; if (ec !== 1 || ek !== 2) begin bad++; $display("FAIL misalign_err got cyc=%0d kind=%0d exp cyc=1 kind=2", ec, ek); end
    total++; if (eca !== 2'b01) begin bad++; $display("FAIL misalign_cause got=%b exp=01", eca); end
    total++; if (rs !== 0 || np !== 1) begin bad++; $display("FAIL misalign_noreq got req=%0d pulses=%0d exp 0/1", rs, np); end
    total++; if (instr !== exp_instr) begin bad++; $display("FAIL misalign_instr got=%h exp=%h", instr, exp_instr); end
  endtask

  task automatic test_ready_stall();
    drive_txn(32'h0000_1230, 5, 1, 1'b0, 32'h0123_4567, -1, 10, ec, ek, ei, eca, np, rs, rb, bo, ra);
    exp_instr = 32'h0123_4567;
    total++; if (rs !== 6 || rb !== 0) begin bad++; $display("FAIL stall_req got seen=%0d bad=%0d exp 6/0", rs, rb); end
    total++; if (ec !== 8 || ek !== 1) begin bad++; $display("FAIL stall_done got cyc=%0d kind=%0d exp cyc=8 kind=1", ec, ek); end
    total++; if (ei !== exp_instr) begin bad++; $display("FAIL stall_instr got=%h exp=%h", ei, exp_instr); end
  endtask

  task automatic test_timeout();
    drive_txn(32'h80, 0, T + 1, 1'b0, 32'hAAAA_5555, -1, T + 5, ec, ek, ei, eca, np, rs, rb, bo, ra);
    exp_cause = 2'b10;
    total++; if (ec !== T + 2 || ek !== 2) begin bad++; $display("FAIL timeout_cyc got cyc=%0d kind=%0d exp cyc=%0d kind=2", ec, ek, T + 2); end
    total++; if (eca !== 2'b10) begin bad++; $display("FAIL timeout_cause got=%b exp=10", eca); end
    total++; if (np !== 1 || instr !== exp_instr) begin bad++; $display("FAIL timeout_late got pulses=%0d instr=%h exp 1/%h", np, instr, exp_instr); end
    drive_txn(32'h84, 0, T, 1'b0, 32'h5A5A_0001, -1, T + 4, ec, ek, ei, eca, np, rs, rb, bo, ra);
    exp_instr = 32'h5A5A_0001;
    total++; if (ec !== T + 2 || ek !== 1 || ei !== exp_instr) begin
      bad++; $display("FAIL timeout_edge got cyc=%0d kind=%0d instr=%h exp cyc=%0d kind=1 instr=%h", ec, ek, ei, T + 2, exp_instr);
    end
  endtask

  task automatic test_bus_err();
    drive_txn(32'h90, 1, 2, 1'b1, 32'hFFFF_0000, -1, 7, ec, ek, ei, eca, np, rs, rb, bo, ra);
    exp_cause = 2'b11;
    total++; if (ec !== 5 || ek !== 2 || eca !== 2'b11) begin
      bad++; $display("FAIL buserr got cyc=%0d kind=%0d cause=%b exp 5/2/11", ec, ek, eca);
    end
    total++; if (instr !== exp_instr) begin bad++; $display("FAIL buserr_instr got=%h exp=%h", instr, exp_instr); end
    total++; if (err_cause !== exp_cause) begin bad++; $display("FAIL cause_hold got=%b exp=%b", err_cause, exp_cause); end
  endtask

  task automatic test_flush();
    drive_txn(32'hA0, 0, 3, 1'b0, 32'h0BAD_0BAD, 2, 7, ec, ek, ei, eca, np, rs, rb, bo, ra);
    total++; if (np !== 0 || ra !== 5) begin bad++; $display("FAIL flush_wait got pulses=%0d ready_at=%0d exp 0/5", np, ra); end
    drive_txn(32'hA4, 3, 1, 1'b0, 32'h0BAD_0001, 2, 7, ec, ek, ei, eca, np, rs, rb, bo, ra);
    total++; if (np !== 0 || ra !== 3 || rs !== 2) begin bad++; $display("FAIL flush_req got pulses=%0d ready_at=%0d req=%0d exp 0/3/2", np, ra, rs); end
    drive_txn(32'hA8, 0, 2, 1'b0, 32'h0BAD_0002, 1, 6, ec, ek, ei, eca, np, rs, rb, bo, ra);
    total++; if (np !== 0 || ra !== 4) begin bad++; $display("FAIL flush_hs got pulses=%0d ready_at=%0d exp 0/4", np, ra); end
    drive_txn(32'hAC, 0, 1, 1'b0, 32'h0BAD_0003, 0, 4, ec, ek, ei, eca, np, rs, rb, bo, ra);
    total++; if (np !== 0 || ra !== 1 || rs !== 0) begin bad++; $display("FAIL flush_idle got pulses=%0d ready_at=%0d req=%0d exp 0/1/0", np, ra, rs); end
    drive_txn(32'hB0, 0, 100, 1'b0, 32'h0BAD_0004, 2, T + 4, ec, ek, ei, eca, np, rs, rb, bo, ra);
    total++; if (np !== 0 || ra !== T + 2) begin bad++; $display("FAIL flush_drain_to got pulses=%0d ready_at=%0d exp 0/%0d", np, ra, T + 2); end
    total++; if (instr !== exp_instr || err_cause !== exp_cause) begin
      bad++; $display("FAIL flush_state got instr=%h cause=%b exp %h/%b", instr, err_cause, exp_instr, exp_cause);
    end
  endtask

  task automatic test_req_ignored();
    int addr_bad;
    addr_bad = 0;
    fetch_req = 1'b1;
    pc = 32'h100;
    tick();
    pc = 32'h200;
    for (int c = 1; c <= 3; c++) begin
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h100) addr_bad++;
      mem_req_ready = (c == 3);
      if (c == 3) fetch_req = 1'b0;
      tick();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'h0000_0113;
    tick();
    mem_rsp_valid = 1'b0;
    exp_instr = 32'h0000_0113;
    total++; if (addr_bad !== 0) begin bad++; $display("FAIL busy_req_addr got bad=%0d exp 0", addr_bad); end
    total++; if (instr_valid !== 1'b1 || instr !== exp_instr) begin
      bad++; $display("FAIL busy_req_done got v=%b instr=%h exp 1/%h", instr_valid, instr, exp_instr);
    end
    tick();
    total++; if (mem_req_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      bad++; $display("FAIL busy_req_queued got req=%b ready=%b exp 0/1", mem_req_valid, fetch_ready);
    end
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    pulses = 0;
    fetch_req = 1'b1;
    pc = 32'h300;
    tick();
    fetch_req = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (fetch_ready !== 1'b1 || instr !== 32'h0 || mem_addr !== 32'h0 || err_cause !== 2'b00) begin
      bad++; $display("FAIL rst_mid got ready=%b instr=%h addr=%h cause=%b exp 1/0/0/00", fetch_ready, instr, mem_addr, err_cause);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (instr_valid || fetch_err) pulses++;
      tick();
    end
    exp_instr = '0;
    exp_cause = 2'b00;
    total++; if (pulses !== 0 || instr !== 32'h0) begin bad++; $display("FAIL rst_mid_rsp got pulses=%0d instr=%h exp 0/0", pulses, instr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    int rdly, sdly, xc, xk, xn;
    logic rerr;
    logic [1:0] xca;
    for (int n = 0; n < 40; n++) begin
      a = $urandom & 32'h0000_FFFF;
      if ($urandom_range(4) != 0) a[1:0] = 2'b00;
      rdly = $urandom_range(4);
      sdly = $urandom_range(T + 2, 1);
      rerr = ($urandom_range(3) == 0);
      d = $urandom;
      model_txn(a, rdly, sdly, rerr, xc, xk, xca, xn);
      drive_txn(a, rdly, sdly, rerr, d, -1, rdly + T + 4, ec, ek, ei, eca, np, rs, rb, bo, ra);
      if (xk == 1) exp_instr = d;
      else exp_cause = xca;
      total++; if (ec !== xc || ek !== xk || np !== 1 || bo !== 0) begin
        bad++; $display("FAIL rand_event n=%0d got cyc=%0d kind=%0d pulses=%0d both=%0d exp cyc=%0d kind=%0d", n, ec, ek, np, bo, xc, xk);
      end
      total++; if (instr !== exp_instr || err_cause !== exp_cause) begin
        bad++; $display("FAIL rand_state n=%0d got instr=%h cause=%b exp %h/%b", n, instr, err_cause, exp_instr, exp_cause);
      end
      total++; if (rs !== xn || rb !== 0 || ra !== xc) begin
        bad++; $display("FAIL rand_req n=%0d got req=%0d addr_bad=%0d ready_at=%0d exp %0d/0/%0d", n, rs, rb, ra, xn, xc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_ready_stall();
    test_timeout();
    test_bus_err();
    test_flush();
    test_req_ignored();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
